// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: word-addressed synchronous instruction memory with valid/ready fetch and 2-entry response buffer.
module instr_mem_fetch #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = "",
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
`ifdef IMEM_LOAD_PORT_EN
  input  logic             p_LoadEn_In,
  input  logic [IDX_W-1:0] p_LoadAddr_In,
  input  logic [31:0]      p_LoadData_In,
  input  logic [3:0]       p_LoadByteEn_In,
`endif
  input  logic             p_Clk,
  input  logic             p_Reset,
  input  logic             p_Flush_In,
  input  logic             p_ReqValid_In,
  output logic             p_ReqReady_Out,
  input  logic [31:0]      p_ReqAddr_In,
  output logic             p_RspValid_Out,
  input  logic             p_RspReady_In,
  output logic [31:0]      p_RspData_Out,
  output logic             p_RspErr_Out,
  output logic [31:0]      p_RspAddr_Out
);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  logic [31:0] mem [DEPTH_WORDS];
  logic [64:0] e0_q, e0_d, e1_q, e1_d, new_ent, head;
  logic [1:0]  cnt_q, cnt_d, cnt_p;
  logic        infl_q, infl_d, ierr_q, ierr_d;
  logic [31:0] iaddr_q, iaddr_d, rd_data_q, off;
  logic        req_err, accept, rsp_vld, pop, pop_buf, push;
  always_comb begin
    off = p_ReqAddr_In - BASE_ADDR;
    req_err = p_ReqAddr_In[1:0] != 2'b00 || {1'b0, off} >= SPAN;
    new_ent = {iaddr_q, ierr_q, ierr_q ? 32'h0 : rd_data_q};
    rsp_vld = cnt_q != 2'd0 || infl_q;
    head = cnt_q != 2'd0 ? e0_q : infl_q ? new_ent : 65'h0;
    pop = rsp_vld && p_RspReady_In;
    pop_buf = pop && cnt_q != 2'd0;
    push = infl_q && !p_Flush_In && !(pop && cnt_q == 2'd0);
    cnt_p = cnt_q - {1'b0, pop_buf};
    p_ReqReady_Out = !p_Reset && !p_Flush_In && (3'(infl_q) + 3'(cnt_q) - 3'(pop) < 3'd2);
    accept = p_ReqValid_In && p_ReqReady_Out;
    e0_d = push && cnt_p == 2'd0 ? new_ent : pop_buf ? e1_q : e0_q;
    e1_d = push && cnt_p == 2'd1 ? new_ent : e1_q;
    cnt_d = p_Flush_In ? 2'd0 : cnt_p + {1'b0, push};
    infl_d = accept;
    ierr_d = req_err;
    iaddr_d = p_ReqAddr_In;
    p_RspValid_Out = rsp_vld;
    p_RspData_Out = head[31:0];
    p_RspErr_Out = head[32];
    p_RspAddr_Out = head[64:33];
  end
  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      cnt_q <= 2'd0;
      infl_q <= 1'b0;
      ierr_q <= 1'b0;
      iaddr_q <= 32'h0;
      e0_q <= 65'h0;
      e1_q <= 65'h0;
    end else begin
      cnt_q <= cnt_d;
      infl_q <= infl_d;
      ierr_q <= ierr_d;
      iaddr_q <= iaddr_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  always_ff @(posedge p_Clk)
    if (accept && !req_err) rd_data_q <= mem[off[IDX_W+1:2]];
`ifdef IMEM_LOAD_PORT_EN
  always_ff @(posedge p_Clk)
    if (p_LoadEn_In && !p_Reset)
      for (int b = 0; b < 4; b++)
        if (p_LoadByteEn_In[b]) mem[p_LoadAddr_In][8*b +: 8] <= p_LoadData_In[8*b +: 8];
`endif
endmodule
